// File: rtl/decrypt_pipeline_if.sv
// rtl/decrypt_pipeline_if.sv - byte stream bundle for the decrypt pipeline
//
// Purpose: groups the input byte handshake (en/din) and the output byte
//          handshake (v/dout) of decrypt_pipeline.
// Signals:
//   en    1  input byte valid this cycle
//   din   8  encrypted byte
//   v     1  output byte valid
//   dout  8  decrypted byte
// Modports:
//   master  producer/consumer side (drives en/din, observes v/dout)
//   slave   pipeline side (observes en/din, drives v/dout)

interface decrypt_pipeline_if;
  logic       en;
  logic [7:0] din;
  logic       v;
  logic [7:0] dout;

  modport master (output en, output din, input v, input dout);
  modport slave  (input en, input din, output v, output dout);
endinterface

// File: rtl/decrypt_pipeline.sv
// rtl/decrypt_pipeline.sv - 3-stage byte decryption pipeline (XOR, nibble swap, Caesar unshift)
//
// Purpose: inverse of the encrypt pipe. Each accepted byte is XORed with a
//          rotating key, nibble-swapped, then Caesar-unshifted if it is an
//          ASCII letter. Full throughput, fixed 3-cycle latency, no backpressure.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   bus        decrypt_pipeline_if.slave (en, din in; v, dout out)
//   k1,k2,k3   key bytes for key index 0/1/2
//   rot_freq   key-rotation period in accepted bytes, 0 = no rotation
//   shift_en   apply inverse Caesar shift
//   shift_amt  Caesar shift amount 0..15
//   mode       1 = decrypt, 0 = bypass (same latency)
// Configuration macro:
//   DECRYPT_KEY_ROT_EN  defined: rotating key schedule over k1/k2/k3;
//                       undefined: k1 only, rot_freq/k2/k3 ignored.

module decrypt_pipeline (
  input  logic                clk,
  input  logic                rst,
  decrypt_pipeline_if.slave   bus,
  input  logic [7:0]          k1,
  input  logic [7:0]          k2,
  input  logic [7:0]          k3,
  input  logic [2:0]          rot_freq,
  input  logic                shift_en,
  input  logic [3:0]          shift_amt,
  input  logic                mode
);

  logic [7:0] key;

`ifdef DECRYPT_KEY_ROT_EN
  logic [2:0] cnt;
  logic [1:0] idx;
  logic [1:0] idx_eff;

  // rot_freq=0 pins the key to k1 even if idx was left elsewhere.
  assign idx_eff = (rot_freq == 3'd0) ? 2'd0 : idx;

  always_comb begin
    key = k1;
    case (idx_eff)
      2'd0:    key = k1;
      2'd1:    key = k2;
      default: key = k3;
    endcase
  end

  // Current byte uses idx; the advance takes effect for the next byte.
  // Using >= lets a rot_freq that drops to or below cnt roll over on the
  // very next accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
      idx <= 2'd0;
    end else if (bus.en) begin
      if (rot_freq == 3'd0) begin
        cnt <= 3'd0;
        idx <= 2'd0;
      end else if (({1'b0, cnt} + 4'd1) >= {1'b0, rot_freq}) begin
        cnt <= 3'd0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end
`else
  logic unused_rot_cfg;

  assign key            = k1;
  assign unused_rot_cfg = ^{k2, k3, rot_freq};
`endif

  // Stage 1: XOR with the key; controls are captured here and ride along.
  logic       s1_v;
  logic [7:0] s1_data;
  logic       s1_mode;
  logic       s1_shen;
  logic [3:0] s1_amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= 8'h00;
      s1_mode <= 1'b0;
      s1_shen <= 1'b0;
      s1_amt  <= 4'd0;
    end else begin
      s1_v <= bus.en;
      if (bus.en) begin
        s1_data <= mode ? (bus.din ^ key) : bus.din;
        s1_mode <= mode;
        s1_shen <= shift_en;
        s1_amt  <= shift_amt;
      end
    end
  end

  // Stage 2: nibble swap. Mode and shift enable collapse into one flag.
  logic       s2_v;
  logic [7:0] s2_data;
  logic       s2_unshift;
  logic [3:0] s2_amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v       <= 1'b0;
      s2_data    <= 8'h00;
      s2_unshift <= 1'b0;
      s2_amt     <= 4'd0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data    <= s1_mode ? {s1_data[3:0], s1_data[7:4]} : s1_data;
        s2_unshift <= s1_mode & s1_shen;
        s2_amt     <= s1_amt;
      end
    end
  end

  // Stage 3: inverse Caesar shift on letters.
  // 'A' and 'a' both have low five bits = 1, so the alphabet position is
  // data[4:0]-1 for either case and the case bits [7:5] pass through.
  logic       is_letter;
  logic [4:0] letter_pos;
  logic [5:0] off;
  logic [4:0] wrapped;
  logic [7:0] unshifted;

  always_comb begin
    is_letter  = ((s2_data >= 8'h41) && (s2_data <= 8'h5A)) ||
                 ((s2_data >= 8'h61) && (s2_data <= 8'h7A));
    letter_pos = s2_data[4:0] - 5'd1;
    off        = {1'b0, letter_pos} - {2'b00, s2_amt};
    // off is in -15..25; a negative value wraps by adding 26 (mod 32 is safe).
    wrapped    = off[5] ? (off[4:0] + 5'd26) : off[4:0];
    unshifted  = (is_letter && s2_unshift) ? {s2_data[7:5], wrapped + 5'd1} : s2_data;
  end

  logic       v_q;
  logic [7:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      v_q <= s2_v;
      if (s2_v) begin
        dout_q <= unshifted;
      end
    end
  end

  assign bus.v    = v_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_decrypt_pipeline.sv
// tb/tb_decrypt_pipeline.sv - directed self-checking bench for decrypt_pipeline

module tb_decrypt_pipeline;

`ifdef DECRYPT_KEY_ROT_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       shift_en;
  logic [3:0] shift_amt;
  logic       mode;

  decrypt_pipeline_if bus ();

  decrypt_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .k1        (k1),
    .k2        (k2),
    .k3        (k3),
    .rot_freq  (rot_freq),
    .shift_en  (shift_en),
    .shift_amt (shift_amt),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       st_en   [0:15];
  logic [7:0] st_din  [0:15];
  logic       st_mode [0:15];
  logic [7:0] st_exp  [0:15];
  int         st_n;

  task automatic clr_seq();
    st_n = 0;
  endtask

  task automatic push(input logic e, input logic [7:0] d, input logic m, input logic [7:0] x);
    st_en[st_n]   = e;
    st_din[st_n]  = d;
    st_mode[st_n] = m;
    st_exp[st_n]  = x;
    st_n++;
  endtask

  // Entered and left just after a rising edge. Entry i is driven in cycle i
  // and must show up on v/dout three edges later.
  task automatic run_seq(input string name);
    for (int i = 0; i < st_n + 3; i++) begin
      if (i >= 3) begin
        total++;
        if (bus.v !== st_en[i-3]) begin
          bad++;
          $display("FAIL %s v[%0d]: got %b want %b", name, i-3, bus.v, st_en[i-3]);
        end else if (st_en[i-3]) begin
          total++;
          if (bus.dout !== st_exp[i-3]) begin
            bad++;
            $display("FAIL %s dout[%0d]: got %h want %h", name, i-3, bus.dout, st_exp[i-3]);
          end
        end
      end
      if (i < st_n) begin
        bus.en  = st_en[i];
        bus.din = st_din[i];
        mode    = st_mode[i];
      end else begin
        bus.en  = 1'b0;
        bus.din = 8'h00;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.din = 8'h00;
    k1 = 8'h11; k2 = 8'hFF; k3 = 8'hDE;
    rot_freq = 3'd0; shift_en = 1'b1; shift_amt = 4'd1; mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.v !== 1'b0) begin bad++; $display("FAIL reset_v: got %b want 0", bus.v); end
    total++;
    if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
    rst = 1'b0;
  endtask

  task automatic test_non_letter();
    rot_freq = 3'd0; k1 = 8'h11; shift_en = 1'b1; shift_amt = 4'd1;
    clr_seq();
    push(1, 8'hD3, 1, 8'h2C);
    run_seq("non_letter");
  endtask

  task automatic test_letters();
    shift_amt = 4'd1;
    clr_seq();
    push(1, 8'h35, 1, 8'h41);   // 'B' -> 'A'
    push(1, 8'h07, 1, 8'h7A);   // 'a' -> 'z'
    push(1, 8'h15, 1, 8'h40);   // '@' just below 'A'
    push(1, 8'hA4, 1, 8'h5B);   // '[' just above 'Z'
    run_seq("letters_amt1");
    shift_amt = 4'd15;
    clr_seq();
    push(1, 8'h05, 1, 8'h4C);   // 'A' - 15 -> 'L'
    push(1, 8'hB6, 1, 8'h6B);   // 'z' - 15 -> 'k'
    run_seq("letters_amt15");
    shift_amt = 4'd0;
    clr_seq();
    push(1, 8'h35, 1, 8'h42);   // identity
    run_seq("letters_amt0");
  endtask

  task automatic test_key_rot();
    rot_freq = 3'd2; k1 = 8'h11; k2 = 8'hFF; k3 = 8'hDE; shift_en = 1'b0;
    clr_seq();
    push(1, 8'h00, 1, 8'h11);
    push(1, 8'h00, 1, 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hFF : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hFF : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hED : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hED : 8'h11);
    push(1, 8'h00, 1, 8'h11);
    run_seq("key_rot");
  endtask

  // Continues from key_rot: idx=0, cnt=1.
  task automatic test_bubbles();
    clr_seq();
    push(1, 8'h00, 1, 8'h11);
    push(0, 8'h00, 1, 8'h00);
    push(1, 8'h00, 1, ROT ? 8'hFF : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hFF : 8'h11);
    push(0, 8'h00, 1, 8'h00);
    push(0, 8'h00, 1, 8'h00);
    push(1, 8'h00, 1, ROT ? 8'hED : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hED : 8'h11);
    push(0, 8'h00, 1, 8'h00);
    push(1, 8'h00, 1, 8'h11);
    run_seq("bubbles");
  endtask

  // Continues with cnt=1; dropping rot_freq to 1 rolls over after the next byte.
  task automatic test_rot_change();
    rot_freq = 3'd1;
    clr_seq();
    push(1, 8'h00, 1, 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hFF : 8'h11);
    push(1, 8'h00, 1, ROT ? 8'hED : 8'h11);
    push(1, 8'h00, 1, 8'h11);
    run_seq("rot_change");
  endtask

  task automatic test_bypass();
    rot_freq = 3'd0; k1 = 8'h11; shift_en = 1'b1; shift_amt = 4'd1;
    clr_seq();
    push(1, 8'hD3, 0, 8'hD3);
    push(1, 8'hD3, 1, 8'h2C);
    push(1, 8'h35, 0, 8'h35);
    push(1, 8'h35, 1, 8'h41);
    push(1, 8'h07, 0, 8'h07);
    run_seq("bypass_toggle");
  endtask

  task automatic test_reset_in_flight();
    rot_freq = 3'd1; k1 = 8'h11; k2 = 8'hFF; k3 = 8'hDE; shift_en = 1'b0; mode = 1'b1;
    bus.en = 1'b1; bus.din = 8'h00;
    @(posedge clk); #1;
    bus.en = 1'b1; bus.din = 8'h00;
    @(posedge clk); #1;
    bus.en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.v !== 1'b0) begin bad++; $display("FAIL rst_flight_v[%0d]: got %b want 0", i, bus.v); end
      total++;
      if (bus.dout !== 8'h00) begin bad++; $display("FAIL rst_flight_dout[%0d]: got %h want 00", i, bus.dout); end
      @(posedge clk); #1;
    end
    clr_seq();
    push(1, 8'h00, 1, 8'h11);
    run_seq("after_reset_k1");
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_non_letter();
    test_letters();
    test_key_rot();
    test_bubbles();
    test_rot_change();
    test_bypass();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
